// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle main controller: states, decode keys
// and the datapath select codes driven back to fetch and the datapath.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXE    = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWR  = 4'd5,
    S_WB     = 4'd6,
    S_BR     = 4'd7,
    S_JMP    = 4'd8
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_JMP = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC4 = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  // Exactly one bit set for any IR value; nop covers every unknown encoding.
  typedef struct packed {
    logic r_alu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic jr;
    logic nop;
  } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/funct decode into a one-hot instruction class.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_fn,
  output iclass_t    o_cls
);

  always_comb begin
    o_cls = '0;
    unique case (i_op)
      OP_RTYPE: begin
        unique case (i_fn)
          FN_ADDU, FN_SUBU: o_cls.r_alu = 1'b1;
          FN_JR:            o_cls.jr    = 1'b1;
          default:          o_cls.nop   = 1'b1;
        endcase
      end
      OP_ORI:  o_cls.ori = 1'b1;
      OP_LUI:  o_cls.lui = 1'b1;
      OP_LW:   o_cls.lw  = 1'b1;
      OP_SW:   o_cls.sw  = 1'b1;
      OP_BEQ:  o_cls.beq = 1'b1;
      OP_J:    o_cls.j   = 1'b1;
      OP_JAL:  o_cls.jal = 1'b1;
      default: o_cls.nop = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle Moore controller: latches IR, sequences each instruction and
// drives PC-update and datapath controls plus a retired-instruction counter.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int RET_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             zero,
  output logic             ir_wr,
  output logic             pc_wr,
  output logic [1:0]       npc_sel,
  output logic             j_sel,
  output logic             reg_wr,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic [1:0]       ext_op,
  output logic             mem_wr,
  output logic             retire,
  output logic [RET_W-1:0] ret_cnt,
  output logic [3:0]       state
);

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_ir;
  logic [RET_W-1:0] r_ret_cnt;
  iclass_t          w_cls;
  logic             w_sub;
  logic             w_unused_ir;

  logic       w_ir_wr, w_pc_wr, w_j_sel, w_reg_wr, w_alu_src, w_mem_wr, w_retire;
  logic [1:0] w_npc_sel, w_reg_dst, w_mem_to_reg, w_alu_op, w_ext_op;

  // Register fields are consumed by the datapath, not by this controller.
  assign w_unused_ir = ^r_ir[25:6];
  assign w_sub       = (r_ir[5:0] == FN_SUBU);

  mc_decode u_decode (
    .i_op  (r_ir[31:26]),
    .i_fn  (r_ir[5:0]),
    .o_cls (w_cls)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_ir      <= '0;
      r_ret_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH) r_ir <= instr;
      if (w_retire) r_ret_cnt <= r_ret_cnt + RET_W'(1);
    end
  end

  always_comb begin
    w_next = S_FETCH;
    unique case (r_state)
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
        if (w_cls.r_alu || w_cls.ori || w_cls.lui)   w_next = S_EXE;
        else if (w_cls.lw || w_cls.sw)               w_next = S_MEMADR;
        else if (w_cls.beq)                          w_next = S_BR;
        else if (w_cls.j || w_cls.jal || w_cls.jr)   w_next = S_JMP;
        else                                         w_next = S_FETCH;
      end
      S_EXE:    w_next = S_WB;
      S_MEMADR: w_next = w_cls.lw ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = S_WB;
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_ir_wr      = 1'b0;
    w_pc_wr      = 1'b0;
    w_npc_sel    = NPC_PC4;
    w_j_sel      = 1'b0;
    w_reg_wr     = 1'b0;
    w_reg_dst    = RD_RT;
    w_mem_to_reg = M2R_ALU;
    w_alu_src    = 1'b0;
    w_alu_op     = ALU_ADD;
    w_ext_op     = EXT_ZERO;
    w_mem_wr     = 1'b0;
    w_retire     = 1'b0;
    unique case (r_state)
      S_FETCH: w_ir_wr = 1'b1;
      S_DECODE: begin
        if (w_cls.nop) begin
          w_pc_wr  = 1'b1;
          w_retire = 1'b1;
        end
      end
      S_EXE, S_WB: begin
        if (w_cls.r_alu) begin
          w_alu_op = w_sub ? ALU_SUB : ALU_ADD;
        end else if (w_cls.ori) begin
          w_alu_op  = ALU_OR;
          w_alu_src = 1'b1;
          w_ext_op  = EXT_ZERO;
        end else if (w_cls.lui) begin
          w_alu_op  = ALU_OR;
          w_alu_src = 1'b1;
          w_ext_op  = EXT_LUI;
        end
        if (r_state == S_WB) begin
          w_reg_wr     = 1'b1;
          w_reg_dst    = w_cls.r_alu ? RD_RD : RD_RT;
          w_mem_to_reg = w_cls.lw ? M2R_MEM : M2R_ALU;
          w_pc_wr      = 1'b1;
          w_retire     = 1'b1;
        end
      end
      S_MEMADR, S_MEMRD, S_MEMWR: begin
        w_alu_src = 1'b1;
        w_ext_op  = EXT_SIGN;
        if (r_state == S_MEMWR) begin
          w_mem_wr = 1'b1;
          w_pc_wr  = 1'b1;
          w_retire = 1'b1;
        end
      end
      S_BR: begin
        // zero is only meaningful here, where the ALU is comparing rs and rt.
        w_alu_op  = ALU_SUB;
        w_ext_op  = EXT_SIGN;
        w_npc_sel = zero ? NPC_BR : NPC_PC4;
        w_pc_wr   = 1'b1;
        w_retire  = 1'b1;
      end
      S_JMP: begin
        w_pc_wr  = 1'b1;
        w_retire = 1'b1;
        if (w_cls.jr) begin
          w_npc_sel = NPC_JR;
        end else begin
          w_npc_sel = NPC_JMP;
          w_j_sel   = 1'b1;
          if (w_cls.jal) begin
            w_reg_wr     = 1'b1;
            w_reg_dst    = RD_RA;
            w_mem_to_reg = M2R_PC4;
          end
        end
      end
      default: ;
    endcase
  end

  // Reset must silence every strobe, including the FETCH-state ir_wr.
  assign ir_wr      = w_ir_wr   & ~rst;
  assign pc_wr      = w_pc_wr   & ~rst;
  assign j_sel      = w_j_sel   & ~rst;
  assign reg_wr     = w_reg_wr  & ~rst;
  assign alu_src    = w_alu_src & ~rst;
  assign mem_wr     = w_mem_wr  & ~rst;
  assign retire     = w_retire  & ~rst;
  assign npc_sel    = rst ? 2'b00 : w_npc_sel;
  assign reg_dst    = rst ? 2'b00 : w_reg_dst;
  assign mem_to_reg = rst ? 2'b00 : w_mem_to_reg;
  assign alu_op     = rst ? 2'b00 : w_alu_op;
  assign ext_op     = rst ? 2'b00 : w_ext_op;
  assign ret_cnt    = r_ret_cnt;
  assign state      = r_state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle state/control checks for every
// instruction class, mid-instruction reset and retire-counter wrap.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        zero = 1'b0;

  logic        ir_wr, pc_wr, j_sel, reg_wr, alu_src, mem_wr, retire;
  logic [1:0]  npc_sel, reg_dst, mem_to_reg, alu_op, ext_op;
  logic [15:0] ret_cnt;
  logic [3:0]  state;

  logic        unused4_ir_wr, unused4_pc_wr, unused4_j_sel, unused4_reg_wr;
  logic        unused4_alu_src, unused4_mem_wr, unused4_retire;
  logic [1:0]  unused4_npc_sel, unused4_reg_dst, unused4_mem_to_reg;
  logic [1:0]  unused4_alu_op, unused4_ext_op;
  logic [3:0]  unused4_state;
  logic [3:0]  ret_cnt4;

  int total = 0;
  int bad   = 0;
  int exp_ret = 0;

  localparam logic [31:0] I_ADDU = 32'h00851021;
  localparam logic [31:0] I_SUBU = 32'h00851023;
  localparam logic [31:0] I_LW   = 32'h8C880004;
  localparam logic [31:0] I_SW   = 32'hAC880004;
  localparam logic [31:0] I_ORI  = 32'h34A500FF;
  localparam logic [31:0] I_LUI  = 32'h3C051234;
  localparam logic [31:0] I_BEQ  = 32'h1085FFFF;
  localparam logic [31:0] I_J    = 32'h08000C00;
  localparam logic [31:0] I_JAL  = 32'h0C000C00;
  localparam logic [31:0] I_JR   = 32'h03E00008;
  localparam logic [31:0] I_NOP  = 32'hFC000000;
  localparam logic [31:0] I_RNOP = 32'h00000000;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero),
    .ir_wr(ir_wr), .pc_wr(pc_wr), .npc_sel(npc_sel), .j_sel(j_sel),
    .reg_wr(reg_wr), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src(alu_src), .alu_op(alu_op), .ext_op(ext_op), .mem_wr(mem_wr),
    .retire(retire), .ret_cnt(ret_cnt), .state(state)
  );

  mc_ctrl #(.RET_W(4)) dut4 (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero),
    .ir_wr(unused4_ir_wr), .pc_wr(unused4_pc_wr), .npc_sel(unused4_npc_sel),
    .j_sel(unused4_j_sel), .reg_wr(unused4_reg_wr), .reg_dst(unused4_reg_dst),
    .mem_to_reg(unused4_mem_to_reg), .alu_src(unused4_alu_src),
    .alu_op(unused4_alu_op), .ext_op(unused4_ext_op), .mem_wr(unused4_mem_wr),
    .retire(unused4_retire), .ret_cnt(ret_cnt4), .state(unused4_state)
  );

  logic [16:0] w_ctl;
  assign w_ctl = {ir_wr, pc_wr, npc_sel, j_sel, reg_wr, reg_dst, mem_to_reg,
                  alu_src, alu_op, ext_op, mem_wr, retire};

  function automatic logic [16:0] ctl(input int irw, input int pcw, input int npc,
                                      input int js, input int rw, input int rd,
                                      input int m2r, input int as, input int aop,
                                      input int eop, input int mw, input int ret);
    return {1'(irw), 1'(pcw), 2'(npc), 1'(js), 1'(rw), 2'(rd), 2'(m2r),
            1'(as), 2'(aop), 2'(eop), 1'(mw), 1'(ret)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Check one cycle (state + full control vector), then move to the next.
  task automatic cyc(input string tag, input int st, input logic [16:0] c);
    #1;
    chk({tag, ".st"}, 32'(state), 32'(st));
    chk({tag, ".ctl"}, 32'(w_ctl), 32'(c));
    @(negedge clk);
  endtask

  // FETCH cycle; instr is scrambled afterwards so decoding must come from IR.
  task automatic fetch(input string tag, input logic [31:0] w);
    instr = w;
    cyc({tag, ".F"}, 0, ctl(1,0,0,0,0,0,0,0,0,0,0,0));
    instr = ~w;
  endtask

  task automatic chk_ret(input string tag);
    exp_ret++;
    #1;
    chk({tag, ".cnt"}, 32'(ret_cnt), 32'(exp_ret));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst.ctl", 32'(w_ctl), 32'h0);
    chk("rst.st",  32'(state), 32'h0);
    chk("rst.cnt", 32'(ret_cnt), 32'h0);
    rst = 1'b0;

    fetch("addu", I_ADDU);
    cyc("addu.D",  1, ctl(0,0,0,0,0,0,0,0,0,0,0,0));
    cyc("addu.E",  2, ctl(0,0,0,0,0,0,0,0,0,0,0,0));
    cyc("addu.WB", 6, ctl(0,1,0,0,1,1,0,0,0,0,0,1));
    chk_ret("addu");

    fetch("subu", I_SUBU);
    cyc("subu.D",  1, ctl(0,0,0,0,0,0,0,0,0,0,0,0));
    cyc("subu.E",  2, ctl(0,0,0,0,0,0,0,0,1,0,0,0));
    cyc("subu.WB", 6, ctl(0,1,0,0,1,1,0,0,1,0,0,1));
    chk_ret("subu");

    fetch("lw", I_LW);
    cyc("lw.D",  1, ctl(0,0,0,0,0,0,0,0,0,0,0,0));
    cyc("lw.MA", 3, ctl(0,0,0,0,0,0,0,1,0,1,0,0));
    cyc("lw.MR", 4, ctl(0,0,0,0,0,0,0,1,0,1,0,0));
    cyc("lw.WB", 6, ctl(0,1,0,0,1,0,1,0,0,0,0,1));
    chk_ret("lw");

    fetch("sw", I_SW);
    cyc("sw.D",  1, ctl(0,0,0,0,0,0,0,0,0,0,0,0));
    cyc("sw.MA", 3, ctl(0,0,0,0,0,0,0,1,0,1,0,0));
    cyc("sw.MW", 5, ctl(0,1,0,0,0,0,0,1,0,1,1,1));
    chk_ret("sw");

    fetch("ori", I_ORI);
    cyc("ori.D",  1, ctl(0,0,0,0,0,0,0,0,0,0,0,0));
    cyc("ori.E",  2, ctl(0,0,0,0,0,0,0,1,2,0,0,0));
    cyc("ori.WB", 6, ctl(0,1,0,0,1,0,0,1,2,0,0,1));
    chk_ret("ori");

    fetch("lui", I_LUI);
    cyc("lui.D",  1, ctl(0,0,0,0,0,0,0,0,0,0,0,0));
    cyc("lui.E",  2, ctl(0,0,0,0,0,0,0,1,2,2,0,0));
    cyc("lui.WB", 6, ctl(0,1,0,0,1,0,0,1,2,2,0,1));
    chk_ret("lui");

    fetch("beq1", I_BEQ);
    zero = 1'b0;
    cyc("beq1.D",  1, ctl(0,0,0,0,0,0,0,0,0,0,0,0));
    zero = 1'b1;
    cyc("beq1.BR", 7, ctl(0,1,1,0,0,0,0,0,1,1,0,1));
    chk_ret("beq1");

    fetch("beq0", I_BEQ);
    zero = 1'b1;
    cyc("beq0.D",  1, ctl(0,0,0,0,0,0,0,0,0,0,0,0));
    zero = 1'b0;
    cyc("beq0.BR", 7, ctl(0,1,0,0,0,0,0,0,1,1,0,1));
    chk_ret("beq0");

    fetch("j", I_J);
    zero = 1'b1;
    cyc("j.D",   1, ctl(0,0,0,0,0,0,0,0,0,0,0,0));
    cyc("j.JMP", 8, ctl(0,1,2,1,0,0,0,0,0,0,0,1));
    chk_ret("j");
    zero = 1'b0;

    fetch("jal", I_JAL);
    cyc("jal.D",   1, ctl(0,0,0,0,0,0,0,0,0,0,0,0));
    cyc("jal.JMP", 8, ctl(0,1,2,1,1,2,2,0,0,0,0,1));
    chk_ret("jal");

    fetch("jr", I_JR);
    cyc("jr.D",   1, ctl(0,0,0,0,0,0,0,0,0,0,0,0));
    cyc("jr.JMP", 8, ctl(0,1,3,0,0,0,0,0,0,0,0,1));
    chk_ret("jr");

    fetch("nop", I_NOP);
    cyc("nop.D", 1, ctl(0,1,0,0,0,0,0,0,0,0,0,1));
    chk_ret("nop");
    chk("nop.next", 32'(state), 32'h0);

    fetch("rnop", I_RNOP);
    cyc("rnop.D", 1, ctl(0,1,0,0,0,0,0,0,0,0,0,1));
    chk_ret("rnop");

    // Reset during lw MEMRD: everything silent, counter cleared.
    fetch("lwr", I_LW);
    cyc("lwr.D",  1, ctl(0,0,0,0,0,0,0,0,0,0,0,0));
    cyc("lwr.MA", 3, ctl(0,0,0,0,0,0,0,1,0,1,0,0));
    #1;
    chk("lwr.MR.st", 32'(state), 32'd4);
    rst = 1'b1;
    #1;
    chk("lwr.rst.st",  32'(state), 32'h0);
    chk("lwr.rst.ctl", 32'(w_ctl), 32'h0);
    chk("lwr.rst.cnt", 32'(ret_cnt), 32'h0);
    @(negedge clk);
    #1;
    chk("lwr.hold.ctl", 32'(w_ctl), 32'h0);
    chk("lwr.hold.st",  32'(state), 32'h0);
    rst = 1'b0;
    exp_ret = 0;

    for (int i = 0; i < 17; i++) begin
      fetch("wrap", I_NOP);
      cyc("wrap.D", 1, ctl(0,1,0,0,0,0,0,0,0,0,0,1));
      exp_ret++;
    end
    #1;
    chk("wrap.cnt16", 32'(ret_cnt), 32'(exp_ret));
    chk("wrap.cnt4",  32'(ret_cnt4), 32'd1);
    chk("wrap.st",    32'(state), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle main controller. It sits on the instruction side of the fetch unit's control interface: it latches the fetched instruction, sequences each instruction through a Moore state machine, and drives the PC-update controls `pc_wr`, `npc_sel` and `j_sel` back to the fetch unit. It also drives the datapath controls for the register file, ALU, extender and data memory. Supported instructions: addu, subu, jr, ori, lui, lw, sw, beq, j, jal.

## Interface
- `RET_W`, default 16: width of the retired-instruction counter.
- `clk  in  1`: clock.
- `rst  in  1`: reset, asynchronous, active-high.
- `instr  in  32`: instruction word from the fetch unit; combinational from the current PC.
- `zero  in  1`: ALU equal flag; sampled only in BR.
- `ir_wr  out  1`: IR load strobe.
- `pc_wr  out  1`: PC write enable to the fetch unit.
- `npc_sel  out  2`: next-PC source. 00 = PC+4, 01 = PC+4+(sext(imm16)<<2), 10 = jump target, 11 = jr register value.
- `j_sel  out  1`: 1 selects the {PC[31:28], imm26, 00} target.
- `reg_wr  out  1`: register-file write enable.
- `reg_dst  out  2`: 00 = rt, 01 = rd, 10 = $31.
- `mem_to_reg  out  2`: 00 = ALU, 01 = memory, 10 = PC+4.
- `alu_src  out  1`: 1 selects the extended immediate.
- `alu_op  out  2`: 00 = add, 01 = sub, 10 = or.
- `ext_op  out  2`: 00 = zero-extend, 01 = sign-extend, 10 = lui (imm16<<16).
- `mem_wr  out  1`: data-memory write enable.
- `retire  out  1`: one-cycle pulse in each instruction's final state.
- `ret_cnt  out  RET_W`: count of retired instructions.
- `state  out  4`: current state, for debug.

## Operation
- IR loads `instr` at the end of FETCH. All decoding uses IR, never `instr`.
- States, in their 4-bit encoding:
  - FETCH = 0
  - DECODE = 1
  - EXE = 2
  - MEMADR = 3
  - MEMRD = 4
  - MEMWR = 5
  - WB = 6
  - BR = 7
  - JMP = 8
- Transitions:
  - FETCH -> DECODE.
  - DECODE -> EXE for addu, subu, ori, lui.
  - DECODE -> MEMADR for lw, sw.
  - DECODE -> BR for beq.
  - DECODE -> JMP for j, jal, jr.
  - DECODE -> FETCH for any other encoding; that cycle retires it as a nop with `pc_wr` = 1 and `npc_sel` = 00.
  - EXE -> WB.
  - MEMADR -> MEMRD for lw; MEMADR -> MEMWR for sw.
  - MEMRD -> WB.
  - WB, MEMWR, BR, JMP -> FETCH.
- Outputs are Moore functions of state and IR. All outputs are 0 unless listed.
  - FETCH: `ir_wr` = 1.
  - EXE and WB: `alu_op` and `ext_op` per instruction. addu: `alu_op` 00. subu: `alu_op` 01. ori: `alu_op` 10, `alu_src` 1, `ext_op` 00. lui: `alu_op` 10, `alu_src` 1, `ext_op` 10.
  - MEMADR, MEMRD, MEMWR: `alu_op` 00, `alu_src` 1, `ext_op` 01.
  - MEMWR: additionally `mem_wr` = 1.
  - WB: `reg_wr` = 1. `reg_dst` = 01 for R-type, else 00. `mem_to_reg` = 01 for lw, else 00.
  - BR: `alu_op` = 01, `ext_op` = 01.
- The PC is written exactly once per instruction, in its final state, with `pc_wr` = 1 and `retire` = 1:
  - WB and MEMWR: `npc_sel` = 00.
  - BR: `npc_sel` = 01 if `zero` = 1, else 00.
  - JMP for j: `npc_sel` = 10, `j_sel` = 1.
  - JMP for jal: as j, plus `reg_wr` = 1, `reg_dst` = 10, `mem_to_reg` = 10.
  - JMP for jr: `npc_sel` = 11.
- Decode keys, opcode then funct:
  - R-type = 000000, with funct addu 100001, subu 100011, jr 001000. Any other funct is a nop.
  - ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.

## Timing
- Cycles per instruction:
  - lw: 5.
  - addu, subu, ori, lui, sw: 4.
  - beq, j, jal, jr: 3.
  - nop: 2.
- The PC changes on the clock edge that ends the final state. PC+4 and the branch target are therefore formed from the old PC, and jal's link value (PC+4) is written in the same edge.
- `ret_cnt` increments on that same edge and wraps from 2^RET_W−1 to 0.
- Reset: `state` = FETCH, IR = 0, `ret_cnt` = 0. Every output is forced to 0 while `rst` is high, including `ir_wr`.
- Reset asserted mid-instruction aborts it with no PC or register write. The first FETCH follows `rst` deassertion.
- `zero` is ignored in every state other than BR.

## Structure
- Package `mc_pkg` holds:
  - the state enum;
  - opcode and funct constants;
  - the `npc_sel`, `reg_dst`, `mem_to_reg`, `alu_op` and `ext_op` encodings.
- Sub-module `mc_decode`: combinational IR -> one-hot instruction class (r_alu, ori, lui, lw, sw, beq, j, jal, jr, nop).
- `mc_ctrl` contains IR, the state register, the output logic and the retire counter.

## Test plan
- Reset: hold `rst` for 3 cycles -> all outputs 0, `state` = 0, `ret_cnt` = 0. First cycle after release -> `ir_wr` = 1.
- addu 0x00851021 -> states 0,1,2,6. In WB: `reg_wr` = 1, `reg_dst` = 01, `pc_wr` = 1, `npc_sel` = 00. `ret_cnt` = 1.
- lw 0x8C880004 -> states 0,1,3,4,6. In WB: `mem_to_reg` = 01, `reg_dst` = 00. sw 0xAC880004 -> states 0,1,3,5 with `mem_wr` = 1 only in MEMWR.
- beq 0x1085FFFF: with `zero` = 1 -> in BR `npc_sel` = 01, `pc_wr` = 1. With `zero` = 0 -> `npc_sel` = 00. `zero` toggled in DECODE has no effect.
- jal 0x0C000C00 -> in JMP: `npc_sel` = 10, `j_sel` = 1, `reg_wr` = 1, `reg_dst` = 10, `mem_to_reg` = 10. jr 0x03E00008 -> `npc_sel` = 11.
- Opcode 0x3F -> retires in DECODE after 2 cycles with no `reg_wr` or `mem_wr`. `rst` pulsed during lw MEMRD -> no write; FETCH after release. `RET_W` = 4 with 17 instructions -> `ret_cnt` = 1.
